// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the fetch stage
package cpu_pkg;
  localparam int          XLEN      = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FAULT
  } fetch_state_t;
endpackage

// File: rtl/instruction_fifo.sv
// rtl/instruction_fifo.sv - registered in-order instruction buffer with synchronous flush
module instruction_fifo #(
  parameter int             DEPTH     = 2,
  parameter int             WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int            AW        = $clog2(DEPTH),
  localparam int            CW        = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;

  assign w_do_pop = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= RESET_VAL;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      // Callers guarantee no push at full unless a pop happens in the same cycle.
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_do_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(w_do_pop);
    end
  end

  assign o_valid = (r_count != '0);
  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, credit-limited memory fetch and redirect handling; FETCH_PERF_COUNTERS_EN adds perf counters
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instruction_valid,
  output logic [XLEN-1:0] instruction_data,
  output logic [XLEN-1:0] instruction_pc,
  input  logic            instruction_ready,
`ifdef FETCH_PERF_COUNTERS_EN
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stalls,
`endif
  output logic            misaligned_fault
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;

  fetch_state_t      r_state, w_state_next;
  logic [XLEN-1:0]   r_pc;
  logic [CW-1:0]     r_outstanding;
  logic [CW-1:0]     r_drop_count;
  logic [CW-1:0]     w_fifo_count;
  logic [XLEN-1:0]   r_pcq [FIFO_DEPTH];
  logic [AW-1:0]     r_pcq_wr;
  logic [AW-1:0]     r_pcq_rd;
  logic [2*XLEN-1:0] w_head;
  logic              w_misaligned, w_credit, w_req_hs, w_dropping, w_enq, w_deq;

  assign w_misaligned  = (redirect_pc[1:0] != 2'b00);
  assign w_credit      = ({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < SW'(FIFO_DEPTH);
  assign mem_req_valid = (r_state == RUN) && !redirect_valid && w_credit;
  assign mem_req_addr  = r_pc;
  assign w_req_hs      = mem_req_valid && mem_req_ready;
  assign w_dropping    = (r_drop_count != '0);
  assign w_enq         = mem_resp_valid && !redirect_valid && !w_dropping;
  assign w_deq         = instruction_valid && instruction_ready;
  assign misaligned_fault = (r_state == FAULT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == IDLE) w_state_next = RUN;
    if (redirect_valid)  w_state_next = w_misaligned ? FAULT : RUN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_drop_count  <= '0;
      r_pcq_wr      <= '0;
      r_pcq_rd      <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_req_hs) - CW'(mem_resp_valid);
      if (redirect_valid) begin
        // Every request still in flight belongs to the old stream; a response this cycle is one of them.
        r_pc         <= redirect_pc;
        r_drop_count <= r_outstanding - CW'(mem_resp_valid);
        r_pcq_wr     <= '0;
        r_pcq_rd     <= '0;
      end else begin
        if (w_req_hs) begin
          r_pc     <= r_pc + XLEN'(4);
          r_pcq_wr <= r_pcq_wr + AW'(1);
        end
        if (mem_resp_valid && w_dropping) r_drop_count <= r_drop_count - CW'(1);
        if (w_enq) r_pcq_rd <= r_pcq_rd + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_hs) r_pcq[r_pcq_wr] <= r_pc;
  end

  instruction_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .WIDTH     (2 * XLEN),
    .RESET_VAL ({RESET_PC, INSTR_NOP})
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_enq),
    .i_data  ({r_pcq[r_pcq_rd], mem_resp_data}),
    .i_pop   (w_deq),
    .i_flush (redirect_valid),
    .o_valid (instruction_valid),
    .o_head  (w_head),
    .o_count (w_fifo_count)
  );

  assign instruction_data = w_head[XLEN-1:0];
  assign instruction_pc   = w_head[2*XLEN-1:XLEN];

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stalls;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetched <= '0;
      r_perf_stalls  <= '0;
    end else begin
      if (w_deq) r_perf_fetched <= r_perf_fetched + 32'd1;
      if ((r_state == RUN) && !mem_req_valid && (w_fifo_count == '0))
        r_perf_stalls <= r_perf_stalls + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stalls  = r_perf_stalls;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of `decoder`: owns the program counter, issues word-aligned reads to instruction memory over a valid/ready request channel, and buffers in-order responses in a small FIFO. It presents `instruction_data` with its PC to the decoder under a valid/ready handshake. It flushes and restarts on a redirect from the branch/jump logic.

## Interface
- `RESET_PC`, 32'h0000_0000: PC of the first fetch after reset.
- `FIFO_DEPTH`, 2: instruction buffer entries, which also bound outstanding requests; power of two, ≥2.
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-low reset; asserting it (low) clears all state immediately.
- `mem_req_valid`  out  1  fetch request valid.
- `mem_req_ready`  in  1  memory accepts request this cycle.
- `mem_req_addr`  out  32  word-aligned fetch address.
- `mem_resp_valid`  in  1  response data valid. Responses arrive in order and are never back-pressured.
- `mem_resp_data`  in  32  fetched instruction word.
- `redirect_valid`  in  1  PC redirect from branch/jump resolution.
- `redirect_pc`  in  32  redirect target.
- `instruction_valid`  out  1  FIFO head valid.
- `instruction_data`  out  32  FIFO head word, fed to `decoder.instruction_data`.
- `instruction_pc`  out  32  PC of FIFO head.
- `instruction_ready`  in  1  decoder consumes head this cycle.
- `misaligned_fault`  out  1  redirect target had `redirect_pc[1:0] != 0`.

## Operation
- States: IDLE, RUN, FAULT.
  - Reset enters IDLE.
  - IDLE → RUN unconditionally on the next clock.
  - RUN → FAULT on a misaligned redirect.
  - FAULT → RUN on an aligned redirect.
- Issue rule: `mem_req_valid = (state==RUN) && !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH)`.
  - On handshake, the PC advances by 4 (mod 2^32, wraps silently) and `outstanding` increments.
- Each `mem_resp_valid` decrements `outstanding`.
  - If `drop_count > 0`: the response is discarded and `drop_count` decrements.
  - Otherwise: it is enqueued together with its PC, taken from a parallel PC queue.
- Because of the credit rule the FIFO never overflows. An enqueue and a dequeue in the same cycle are legal at full and at empty+1.
- Redirect, any state:
  - FIFO flushed; `instruction_valid` drops next cycle.
  - PC ← `redirect_pc`.
  - `drop_count` ← `outstanding` minus 1 if a response arrives the same cycle (that response is dropped).
  - A request is never issued in the redirect cycle.
- Misaligned redirect: enter FAULT and assert `misaligned_fault`. No requests are issued, but in-flight responses are still drained and dropped.
- A redirect during an active drop overwrites `drop_count` using the same formula.

## Timing
- Reset values:
  - `mem_req_valid` 0, `mem_req_addr` RESET_PC.
  - `instruction_valid` 0, `instruction_data` 32'h0000_0013 (NOP), `instruction_pc` RESET_PC.
  - `misaligned_fault` 0, counters 0.
- First `mem_req_valid` is one cycle after reset deasserts.
- The FIFO is registered: a response in cycle N produces `instruction_valid` in N+1. There is no combinational path from `mem_resp_*` or `instruction_ready` to `mem_req_valid`.
- After a redirect in cycle N, `mem_req_addr == redirect_pc` with `mem_req_valid` in N+1 (aligned target, RUN, credit available).
- `instruction_valid` is held with stable data until `instruction_ready`.
- Reset mid-operation discards all outstanding and buffered state. Responses arriving after reset for pre-reset requests are a system error and are not handled.

## Configuration
- `FETCH_PERF_COUNTERS_EN` defined: adds outputs `perf_fetched` (32, count of handshakes `instruction_valid && instruction_ready`) and `perf_stalls` (32, count of cycles in RUN with `mem_req_valid==0` and FIFO empty). Both reset to 0 and wrap.
- Undefined: the ports and counters do not exist.

## Structure
- `cpu_pkg` holds:
  - `fetch_state_t` (IDLE, RUN, FAULT).
  - `XLEN = 32`.
  - `INSTR_NOP = 32'h0000_0013`.
- Sub-module `instruction_fifo`: parameterized depth, 64-bit entries (data+PC), synchronous flush, `count` output. It provides the registered head.

## Test plan
- Reset release, `mem_req_ready=1`, one-cycle memory latency → requests at 0x0, 0x4, 0x8, …. Decoder sees `32'h0170_0793` at PC 0x0 two cycles after the first request.
- `instruction_ready=0` with FIFO_DEPTH=2 → exactly 2 requests issued, then `mem_req_valid` stays 0. One dequeue → exactly one new request.
- Redirect to 0x100 with 2 outstanding → both responses dropped, next request addr 0x100, first `instruction_pc` 0x100.
- Redirect coinciding with a response → that response is not enqueued, and `drop_count` equals the remaining outstanding requests.
- Redirect to 0x102 → `misaligned_fault=1` and no requests. Redirect to 0x200 → fault clears and fetch resumes at 0x200.
- PC at 0xFFFF_FFFC → the next request address wraps to 0x0000_0000.
